// File: rtl/seg_count_display.sv
// rtl/seg_count_display.sv - 4-bit count tracker and 2-digit multiplexed seven-segment driver
// Optional wrap blink enabled by defining SEG_WRAP_BLINK_EN.
module seg_count_display #(
  parameter int REFRESH_CYCLES = 4,
  parameter int CNT_W          = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] count,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       dir,
  output logic       wrap,
  output logic       jump
);

  logic [3:0]       r_count_q;
  logic [3:0]       r_disp_val;
  logic [CNT_W-1:0] r_ref_cnt;
  logic             r_sel;

  logic       w_boundary;
  logic [3:0] w_inc;
  logic [3:0] w_dec;
  logic       w_tens;
  logic [3:0] w_ones;
  logic       w_blank;
  logic [6:0] w_seg_nxt;
  logic [1:0] w_an_nxt;

  assign w_boundary = (r_ref_cnt == CNT_W'(REFRESH_CYCLES - 1));
  assign w_inc      = r_count_q + 4'd1;
  assign w_dec      = r_count_q - 4'd1;
  assign w_tens     = (r_disp_val >= 4'd10);
  assign w_ones     = w_tens ? (r_disp_val - 4'd10) : r_disp_val;

  function automatic logic [6:0] f_pattern(input logic [3:0] d);
    case (d)
      4'd0:    f_pattern = 7'b1000000;
      4'd1:    f_pattern = 7'b1111001;
      4'd2:    f_pattern = 7'b0100100;
      4'd3:    f_pattern = 7'b0110000;
      4'd4:    f_pattern = 7'b0011001;
      4'd5:    f_pattern = 7'b0010010;
      4'd6:    f_pattern = 7'b0000010;
      4'd7:    f_pattern = 7'b1111000;
      4'd8:    f_pattern = 7'b0000000;
      4'd9:    f_pattern = 7'b0010000;
      default: f_pattern = 7'h7F;
    endcase
  endfunction

`ifdef SEG_WRAP_BLINK_EN
  logic [1:0] r_blink;

  // A fresh wrap restarts the blank period even if one is already running.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_blink <= 2'd0;
    end else if (wrap) begin
      r_blink <= 2'd2;
    end else if (w_boundary && (r_blink != 2'd0)) begin
      r_blink <= r_blink - 2'd1;
    end
  end

  assign w_blank = (r_blink != 2'd0);
`else
  assign w_blank = 1'b0;
`endif

  always_comb begin
    w_an_nxt  = 2'b11;
    w_seg_nxt = 7'h7F;
    if (!w_blank) begin
      if (!r_sel) begin
        w_an_nxt  = 2'b10;
        w_seg_nxt = f_pattern(w_ones);
      end else if (w_tens) begin
        w_an_nxt  = 2'b01;
        w_seg_nxt = f_pattern(4'd1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count_q  <= 4'd0;
      r_disp_val <= 4'd0;
      r_ref_cnt  <= '0;
      r_sel      <= 1'b0;
      seg        <= 7'h7F;
      an         <= 2'b11;
      dir        <= 1'b1;
      wrap       <= 1'b0;
      jump       <= 1'b0;
    end else begin
      r_count_q <= count;
      if (count == w_inc) begin
        dir <= 1'b1;
      end else if (count == w_dec) begin
        dir <= 1'b0;
      end
      jump <= (count != r_count_q) && (count != w_inc) && (count != w_dec);
      wrap <= ((r_count_q == 4'd15) && (count == 4'd0)) ||
              ((r_count_q == 4'd0) && (count == 4'd15));

      // Display value only moves at slot boundaries so a digit is stable for a whole slot.
      if (w_boundary) begin
        r_ref_cnt  <= '0;
        r_sel      <= ~r_sel;
        r_disp_val <= r_count_q;
      end else begin
        r_ref_cnt <= r_ref_cnt + CNT_W'(1);
      end

      seg <= w_seg_nxt;
      an  <= w_an_nxt;
    end
  end

endmodule

// File: tb/tb_seg_count_display.sv
// tb/tb_seg_count_display.sv - self-checking bench for seg_count_display
module tb_seg_count_display;

  localparam int R = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] count;
  logic [6:0] seg;
  logic [1:0] an;
  logic       dir;
  logic       wrap;
  logic       jump;

  always #5 clk = ~clk;

  seg_count_display #(.REFRESH_CYCLES(R), .CNT_W(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .count (count),
    .seg   (seg),
    .an    (an),
    .dir   (dir),
    .wrap  (wrap),
    .jump  (jump)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [6:0] pat [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  // Reference state: edges since reset, last sampled count, shown value, blink slots left.
  int         m_n;
  int         m_prev;
  int         m_disp;
  int         m_blink;
  logic [6:0] e_seg;
  logic [1:0] e_an;
  logic       e_dir;
  logic       e_wrap;
  logic       e_jump;

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input logic r, input logic [3:0] c);
    int  sel, diff, tens, ones;
    bit  blank, boundary;
    if (r) begin
      m_n = 0; m_prev = 0; m_disp = 0; m_blink = 0;
      e_seg = 7'h7F; e_an = 2'b11; e_dir = 1'b1; e_wrap = 1'b0; e_jump = 1'b0;
    end else begin
      sel      = (m_n / R) % 2;
      boundary = ((m_n % R) == R - 1);
      tens     = m_disp / 10;
      ones     = m_disp % 10;
`ifdef SEG_WRAP_BLINK_EN
      blank = (m_blink > 0);
      if (e_wrap) m_blink = 2;
      else if (boundary && m_blink > 0) m_blink = m_blink - 1;
`else
      blank = 1'b0;
`endif
      if (blank) begin
        e_an = 2'b11; e_seg = 7'h7F;
      end else if (sel == 0) begin
        e_an = 2'b10; e_seg = pat[ones];
      end else if (tens == 1) begin
        e_an = 2'b01; e_seg = pat[1];
      end else begin
        e_an = 2'b11; e_seg = 7'h7F;
      end
      if (boundary) m_disp = m_prev;
      diff   = (int'(c) - m_prev + 16) % 16;
      e_wrap = (diff == 1 && c == 4'd0) || (diff == 15 && c == 4'd15);
      e_jump = (diff != 0) && (diff != 1) && (diff != 15);
      if (diff == 1) e_dir = 1'b1;
      else if (diff == 15) e_dir = 1'b0;
      m_prev = int'(c);
      m_n    = m_n + 1;
    end
  endtask

  task automatic step(input logic r, input logic [3:0] c);
    @(negedge clk);
    rst   = r;
    count = c;
    @(posedge clk);
    model_update(r, c);
    #1;
    check("seg", seg, e_seg);
    check("an", {5'b0, an}, {5'b0, e_an});
    check("dir", {6'b0, dir}, {6'b0, e_dir});
    check("wrap", {6'b0, wrap}, {6'b0, e_wrap});
    check("jump", {6'b0, jump}, {6'b0, e_jump});
    check("an_not_both_low", {6'b0, (an == 2'b00)}, 7'd0);
  endtask

  initial begin
    logic [3:0] c;
    int         hunt;
    rst   = 1'b1;
    count = 4'd9;

    // Reset held with a nonzero count on the input.
    for (int i = 0; i < 3; i++) step(1'b1, 4'd9);

    // Constant 7: blank tens, ones shows 7.
    for (int i = 0; i < 12; i++) step(1'b0, 4'd7);

    // Constant 12: tens shows 1, ones shows 2.
    for (int i = 0; i < 12; i++) step(1'b0, 4'd12);

    // Upward run across 15->0.
    step(1'b0, 4'd13); step(1'b0, 4'd14); step(1'b0, 4'd15); step(1'b0, 4'd0); step(1'b0, 4'd1);
    for (int i = 0; i < 14; i++) step(1'b0, 4'd1);

    // Downward run across 0->15.
    step(1'b0, 4'd2); step(1'b0, 4'd1); step(1'b0, 4'd0); step(1'b0, 4'd15); step(1'b0, 4'd14);
    for (int i = 0; i < 14; i++) step(1'b0, 4'd14);

    // Jump 3->9, then reset during the tens slot.
    step(1'b0, 4'd3);
    step(1'b0, 4'd9);
    hunt = 0;
    while (((m_n / R) % 2) != 1 && hunt < 20) begin
      step(1'b0, 4'd9);
      hunt++;
    end
    check("tens_slot_reached", {6'b0, (hunt < 20)}, 7'd1);
    step(1'b1, 4'd9);
    for (int i = 0; i < 10; i++) step(1'b0, 4'd9);

    // Random walk mixing steps, holds, jumps and occasional resets.
    c = 4'd9;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       c = c + 4'd1;
        1:       c = c - 4'd1;
        2:       c = c;
        default: c = 4'($urandom_range(0, 15));
      endcase
      step(($urandom_range(0, 49) == 0), c);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
